inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage sitting directly downstream of the PC register. Each cycle it takes the current PC, issues one SRAM-like instruction-bus request, and returns the fetched word with its PC to decode over a valid/ready handshake. It tells the PC register when to advance through `pc_en`, and discards fetches squashed by a pipeline flush. Misaligned PCs are reported as AdEL without touching the bus.

## Interface
- `WIDTH`, 32, address/data width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `pc_i`  in  WIDTH  current PC (PC register `q`).
- `pc_en`  out  1  advance enable to PC register (`en`).
- `flush`  in  1  pipeline flush; same cycle as PC register `clr`.
- `inst_req`  out  1  bus request.
- `inst_addr`  out  WIDTH  request address.
- `inst_addr_ok`  in  1  request accepted this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  WIDTH  read data.
- `if_valid`  out  1  output packet valid.
- `id_ready`  in  1  decode accepts packet.
- `if_pc`  out  WIDTH  PC of packet.
- `if_inst`  out  WIDTH  instruction word (0 when `if_adel`).
- `if_adel`  out  1  fetch address error.

## Operation
- At most one outstanding bus request.
- Output register (`if_*`) plus 1-entry hold register. Transfer to decode when `if_valid & id_ready`. "Output free" means `!if_valid | id_ready`.
- States: S_REQ, S_WAIT, S_DROP, S_HALT.
- **S_REQ, aligned `pc_i`:**
  - `inst_req = !flush & !hold_valid`; `inst_addr = pc_i`.
  - On `inst_addr_ok`: `pc_en = 1`, latch `req_pc = pc_i`, go to S_WAIT.
- **S_REQ, `pc_i[1:0] != 0`:**
  - No request.
  - When output is free and `!hold_valid & !flush`: load output with valid=1, pc=`pc_i`, inst=0, adel=1, then go to S_HALT. `pc_en = 0`.
- **S_WAIT:**
  - On `inst_data_ok`, route {`req_pc`, `inst_rdata`, adel=0} to the output if free, else to hold. Then go to S_REQ.
- **S_HALT:** remain until `flush`.
- **Hold register:** moves to the output whenever the output is free. Hold is always empty when a request issues, so returned data always has a slot.
- **`flush` (highest priority):**
  - Clears `if_valid` and `hold_valid`. `pc_en = 0`; the PC register loads its target.
  - S_WAIT without `inst_data_ok` goes to S_DROP.
  - S_WAIT with `inst_data_ok` discards the data and goes to S_REQ.
  - S_HALT goes to S_REQ. S_REQ stays in S_REQ.
- **S_DROP:** the next `inst_data_ok` is discarded, then go to S_REQ. A `flush` in S_DROP keeps S_DROP.
- **Reset values:**
  - state S_REQ; `if_valid` 0, `if_pc` 0, `if_inst` 0, `if_adel` 0, `hold_valid` 0.
  - `pc_en`, `inst_req` 0 during reset.
- `pc_en`, `inst_req`, `inst_addr` are combinational from state, `pc_i`, `flush`, `hold_valid`, `inst_addr_ok`. All other outputs are registered.

## Timing
- First request is in the first cycle after `rst` falls, with `inst_addr = 32'hbfc00000`.
- `inst_addr_ok` in cycle N puts the new PC on `pc_i` in N+1.
- `inst_data_ok` never occurs in the same cycle as its `inst_addr_ok`; earliest is N+1.
- `inst_data_ok` in cycle M gives `if_valid` in M+1, when the output is free.
- Peak throughput: one instruction per 2 cycles with zero-wait memory.
- Flush in cycle F: earliest new-target request in F+1, or one cycle after the dropped `inst_data_ok`.
- `inst_req` holds with a stable `inst_addr` until `inst_addr_ok` unless `flush`. The bus must tolerate withdrawal on flush.

## Structure
- Shared package `cpu_defs`:
  - state encoding (2-bit enum);
  - reset vector `32'hbfc00000`;
  - ADEL excode constant.
- Sub-module `if_out_buf`: the output register + hold register and its free/valid logic. The FSM and bus handshake stay in `inst_fetch`.

## Test plan
- **Reset then zero-wait memory returning `rdata = addr`:** first `inst_addr` is bfc00000; `if_pc`/`if_inst` sequence bfc00000, bfc00004, bfc00008; `if_valid` every 2nd cycle.
- **`id_ready` low 6 cycles with data returning:** one packet in output, one in hold, no `inst_req`; after release, both drain in order with no loss or duplication.
- **Flush in the cycle after `addr_ok`, `data_ok` 3 cycles later:** that word is never presented; next request uses the flush target (PC register `t` = bfc00380).
- **Flush coincident with `inst_data_ok`:** data dropped, `if_valid` 0 next cycle, FSM in S_REQ.
- **`pc_i` = bfc00002:** no `inst_req`; one packet with `if_adel`=1, `if_inst`=0, `if_pc`=bfc00002; `pc_en` stays 0 until `flush`, then fetch resumes at target.
- **`rst` asserted in S_WAIT:** next cycle state S_REQ, `if_valid` 0; late `inst_data_ok` ignored.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the fetch stage.
//   fetch_state_t : 2-bit fetch FSM encoding
//   RESET_VECTOR  : PC after reset
//   EXC_ADEL      : exception code for an address error on load/fetch
//   pc_aligned()  : word-alignment test on a PC
package cpu_defs;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // ready to issue a request for pc_i
        S_WAIT = 2'd1,  // request accepted, waiting for read data
        S_DROP = 2'd2,  // flushed while waiting; swallow the next data beat
        S_HALT = 2'd3   // address error reported, wait for a flush
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;
    localparam logic [4:0]  EXC_ADEL     = 5'h04;

    function automatic logic pc_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/if_out_buf.sv
// Fetch output register plus a one-entry hold register.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop everything buffered
//   push, push_*      : new packet {pc, inst, adel} entering the buffer
//   id_ready          : decode takes the output packet this cycle
//   out_free          : output register can take a packet this cycle
//   hold_valid        : hold register occupied
//   if_valid/pc/inst/adel : packet presented to decode
module if_out_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_pc,
    input  logic [WIDTH-1:0] push_inst,
    input  logic             push_adel,
    input  logic             id_ready,
    output logic             out_free,
    output logic             hold_valid,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_inst,
    output logic             if_adel
);

    logic [WIDTH-1:0] hold_pc;
    logic [WIDTH-1:0] hold_inst;
    logic             hold_adel;

    assign out_free = !if_valid | id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_inst    <= '0;
            if_adel    <= 1'b0;
            hold_valid <= 1'b0;
            hold_pc    <= '0;
            hold_inst  <= '0;
            hold_adel  <= 1'b0;
        end else if (flush) begin
            if_valid   <= 1'b0;
            hold_valid <= 1'b0;
        end else if (out_free) begin
            if (hold_valid) begin
                // Hold is older than any incoming packet, so it goes first.
                if_valid   <= 1'b1;
                if_pc      <= hold_pc;
                if_inst    <= hold_inst;
                if_adel    <= hold_adel;
                hold_valid <= push;
                if (push) begin
                    hold_pc   <= push_pc;
                    hold_inst <= push_inst;
                    hold_adel <= push_adel;
                end
            end else if (push) begin
                if_valid <= 1'b1;
                if_pc    <= push_pc;
                if_inst  <= push_inst;
                if_adel  <= push_adel;
            end else begin
                if_valid <= 1'b0;
            end
        end else if (push) begin
            // Output stalled: the returning word parks in hold. Requests are
            // only issued with hold empty, so this never overwrites.
            hold_valid <= 1'b1;
            hold_pc    <= push_pc;
            hold_inst  <= push_inst;
            hold_adel  <= push_adel;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage between the PC register and decode.
//   clk, rst          : clock, synchronous active-high reset
//   pc_i, pc_en       : current PC in, advance enable back to the PC register
//   flush             : pipeline flush (PC register loads its target)
//   inst_req/addr     : instruction bus request, addr_ok accepts it
//   inst_data_ok/rdata: read data return
//   if_* / id_ready   : fetched packet to decode, valid/ready handshake
module inst_fetch
    import cpu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    output logic             pc_en,
    input  logic             flush,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             if_valid,
    input  logic             id_ready,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_inst,
    output logic             if_adel
);

    fetch_state_t     state, state_nx;
    logic [WIDTH-1:0] req_pc;
    logic             hold_valid;
    logic             out_free;
    logic             push;
    logic [WIDTH-1:0] push_pc;
    logic [WIDTH-1:0] push_inst;
    logic             push_adel;

    always_comb begin
        state_nx  = state;
        inst_req  = 1'b0;
        inst_addr = pc_i;
        pc_en     = 1'b0;
        push      = 1'b0;
        push_pc   = req_pc;
        push_inst = inst_rdata;
        push_adel = 1'b0;
        if (!rst) begin
            unique case (state)
                S_REQ: begin
                    if (pc_aligned(pc_i[1:0])) begin
                        // Holding off while hold is full guarantees the
                        // returning word always has somewhere to land.
                        inst_req = !flush & !hold_valid;
                        if (inst_req & inst_addr_ok) begin
                            pc_en    = 1'b1;
                            state_nx = S_WAIT;
                        end
                    end else if (out_free & !hold_valid & !flush) begin
                        push      = 1'b1;
                        push_pc   = pc_i;
                        push_inst = '0;
                        push_adel = 1'b1;
                        state_nx  = S_HALT;
                    end
                end
                S_WAIT: begin
                    if (flush)
                        state_nx = inst_data_ok ? S_REQ : S_DROP;
                    else if (inst_data_ok) begin
                        push     = 1'b1;
                        state_nx = S_REQ;
                    end
                end
                S_DROP: begin
                    // The squashed request still owes one data beat; only
                    // once it is gone may a new request be issued.
                    if (inst_data_ok)
                        state_nx = S_REQ;
                end
                S_HALT: begin
                    if (flush)
                        state_nx = S_REQ;
                end
                default: state_nx = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_REQ;
            req_pc <= '0;
        end else begin
            state <= state_nx;
            if (pc_en)
                req_pc <= pc_i;
        end
    end

    if_out_buf #(.WIDTH(WIDTH)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_pc    (push_pc),
        .push_inst  (push_inst),
        .push_adel  (push_adel),
        .id_ready   (id_ready),
        .out_free   (out_free),
        .hold_valid (hold_valid),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .if_adel    (if_adel)
    );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
    import cpu_defs::*;

    localparam logic [31:0] FLUSH_T = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i;
    logic        pc_en;
    logic        flush = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic        id_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    // bench-side environment controls
    logic        mem_accept = 1'b1;
    logic        mem_kill   = 1'b1;
    int          lat        = 1;
    logic        pc_set     = 1'b0;
    logic [31:0] pc_set_val = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_fetch #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_en        (pc_en),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .id_ready     (id_ready),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_adel      (if_adel)
    );

    // PC register model: clr loads the flush target, en advances by 4.
    always_ff @(posedge clk) begin
        if (rst)         pc_i <= RESET_VECTOR;
        else if (pc_set) pc_i <= pc_set_val;
        else if (flush)  pc_i <= FLUSH_T;
        else if (pc_en)  pc_i <= pc_i + 32'd4;
    end

    // Memory model: accepts when mem_accept, returns rdata = addr 'lat'
    // cycles after acceptance. Not reset by rst, so late beats can occur.
    logic        pend = 1'b0;
    int          cnt  = 0;
    logic [31:0] paddr = '0;
    assign inst_addr_ok = inst_req & mem_accept;
    assign inst_data_ok = pend && (cnt == 0);
    assign inst_rdata   = paddr;

    always_ff @(posedge clk) begin
        if (mem_kill) pend <= 1'b0;
        else if (inst_req && inst_addr_ok) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= inst_addr;
        end else if (inst_data_ok) pend <= 1'b0;
        else if (pend && cnt != 0) cnt <= cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Leaves the bench in the first cycle after rst falls (c0).
    task automatic do_reset();
        tick();
        rst = 1'b1; mem_kill = 1'b1; flush = 1'b0; pc_set = 1'b0;
        id_ready = 1'b1; mem_accept = 1'b1; lat = 1;
        tick();
        tick();
        rst = 1'b0; mem_kill = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        pcen;
        logic        vld;
        logic [31:0] pc;
        logic        hv;
    } vec_t;

    vec_t tbl[16];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // zero-wait stream, then a 6-cycle decode stall (c6..c11)
        tbl[0]  = '{1'b1, 1'b1, 32'hbfc00000, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b1, 32'hbfc00004, 1'b1, 1'b1, 32'hbfc00000, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 1'b1, 32'hbfc00008, 1'b1, 1'b1, 32'hbfc00004, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'hbfc0000c, 1'b1, 1'b1, 32'hbfc00008, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hbfc00008, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hbfc00008, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hbfc00008, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hbfc00008, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hbfc00008, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hbfc00008, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 32'hbfc00010, 1'b1, 1'b1, 32'hbfc0000c, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        tbl[15] = '{1'b1, 1'b1, 32'hbfc00014, 1'b1, 1'b1, 32'hbfc00010, 1'b0};

        // reset state
        tick();
        tick();
        mid();
        chk("rst_req",   32'(inst_req), 32'h0);
        chk("rst_pc_en", 32'(pc_en),    32'h0);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", if_pc,         32'h0);
        chk("rst_inst",  if_inst,       32'h0);
        chk("rst_adel",  32'(if_adel),  32'h0);
        chk("rst_state", 32'(dut.state), 32'(S_REQ));

        // stream + stall table
        do_reset();
        for (int i = 0; i < 16; i++) begin
            id_ready = tbl[i].rdy;
            mid();
            chk($sformatf("t%0d_req", i),   32'(inst_req), 32'(tbl[i].req));
            chk($sformatf("t%0d_pc_en", i), 32'(pc_en),    32'(tbl[i].pcen));
            chk($sformatf("t%0d_valid", i), 32'(if_valid), 32'(tbl[i].vld));
            chk($sformatf("t%0d_hold", i),  32'(dut.hold_valid), 32'(tbl[i].hv));
            if (tbl[i].req)
                chk($sformatf("t%0d_addr", i), inst_addr, tbl[i].addr);
            if (tbl[i].vld) begin
                chk($sformatf("t%0d_if_pc", i), if_pc,   tbl[i].pc);
                chk($sformatf("t%0d_inst", i),  if_inst, tbl[i].pc);
                chk($sformatf("t%0d_adel", i),  32'(if_adel), 32'h0);
            end
            tick();
        end

        // flush the cycle after addr_ok, data 3 cycles after the flush
        do_reset();
        lat = 4;
        mid(); chk("fl_c0_req", 32'(inst_req), 32'h1);
        tick(); flush = 1'b1;
        mid(); chk("fl_c1_pc_en", 32'(pc_en), 32'h0);
        tick(); flush = 1'b0;
        mid(); chk("fl_c2_req", 32'(inst_req), 32'h0);
               chk("fl_c2_state", 32'(dut.state), 32'(S_DROP));
        tick();
        mid(); chk("fl_c3_valid", 32'(if_valid), 32'h0);
        tick(); lat = 1;
        mid(); chk("fl_c4_state", 32'(dut.state), 32'(S_DROP));
               chk("fl_c4_req", 32'(inst_req), 32'h0);
        tick();
        mid(); chk("fl_c5_req", 32'(inst_req), 32'h1);
               chk("fl_c5_addr", inst_addr, FLUSH_T);
               chk("fl_c5_valid", 32'(if_valid), 32'h0);
        tick();
        mid(); chk("fl_c6_valid", 32'(if_valid), 32'h0);
        tick();
        mid(); chk("fl_c7_valid", 32'(if_valid), 32'h1);
               chk("fl_c7_pc", if_pc, FLUSH_T);
               chk("fl_c7_inst", if_inst, FLUSH_T);

        // flush coincident with inst_data_ok
        do_reset();
        lat = 2;
        tick();
        tick(); flush = 1'b1;
        mid(); chk("fd_c2_state", 32'(dut.state), 32'(S_WAIT));
        tick(); flush = 1'b0; mem_accept = 1'b0;
        mid(); chk("fd_c3_valid", 32'(if_valid), 32'h0);
               chk("fd_c3_state", 32'(dut.state), 32'(S_REQ));
               chk("fd_c3_req", 32'(inst_req), 32'h1);
               chk("fd_c3_addr", inst_addr, FLUSH_T);
        tick();
        mid(); chk("fd_c4_valid", 32'(if_valid), 32'h0);

        // misaligned PC
        do_reset();
        mem_accept = 1'b0; pc_set = 1'b1; pc_set_val = 32'hbfc00002;
        tick(); pc_set = 1'b0;
        mid(); chk("ma_c1_req", 32'(inst_req), 32'h0);
               chk("ma_c1_pc_en", 32'(pc_en), 32'h0);
        tick(); mem_accept = 1'b1;
        mid(); chk("ma_c2_valid", 32'(if_valid), 32'h1);
               chk("ma_c2_adel", 32'(if_adel), 32'h1);
               chk("ma_c2_inst", if_inst, 32'h0);
               chk("ma_c2_pc", if_pc, 32'hbfc00002);
               chk("ma_c2_state", 32'(dut.state), 32'(S_HALT));
        tick();
        mid(); chk("ma_c3_valid", 32'(if_valid), 32'h0);
               chk("ma_c3_req", 32'(inst_req), 32'h0);
               chk("ma_c3_pc_en", 32'(pc_en), 32'h0);
        tick(); flush = 1'b1;
        mid(); chk("ma_c4_pc_en", 32'(pc_en), 32'h0);
        tick(); flush = 1'b0;
        mid(); chk("ma_c5_req", 32'(inst_req), 32'h1);
               chk("ma_c5_addr", inst_addr, FLUSH_T);
               chk("ma_c5_pc_en", 32'(pc_en), 32'h1);
        tick();
        tick();
        mid(); chk("ma_c7_valid", 32'(if_valid), 32'h1);
               chk("ma_c7_pc", if_pc, FLUSH_T);
               chk("ma_c7_adel", 32'(if_adel), 32'h0);

        // reset while waiting for data; the late beat must be ignored
        do_reset();
        lat = 3;
        tick();
        mid(); chk("rw_c1_state", 32'(dut.state), 32'(S_WAIT));
        rst = 1'b1;
        #1; chk("rw_c1_req", 32'(inst_req), 32'h0);
            chk("rw_c1_pc_en", 32'(pc_en), 32'h0);
        tick(); rst = 1'b0; mem_accept = 1'b0;
        mid(); chk("rw_c2_state", 32'(dut.state), 32'(S_REQ));
               chk("rw_c2_valid", 32'(if_valid), 32'h0);
               chk("rw_c2_addr", inst_addr, RESET_VECTOR);
        tick();
        mid(); chk("rw_c3_state", 32'(dut.state), 32'(S_REQ));
        tick();
        mid(); chk("rw_c4_valid", 32'(if_valid), 32'h0);
               chk("rw_c4_state", 32'(dut.state), 32'(S_REQ));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
